// File: rtl/pow_pipe_elastic.sv
// Elastic squaring pipeline: y = x^(2^e), one squaring stage per pipeline step,
// per-stage handshake with bubble collapse and a 2-entry output skid buffer.
module pow_pipe_elastic #(
    parameter int IW     = 32,
    parameter int OW     = 64,
    parameter int STAGES = 3,
    parameter int EW     = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [IW-1:0] s_data,
    input  logic [EW-1:0] s_exp,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [OW-1:0] m_data,
    output logic          m_ovf,
    output logic          busy
);
    localparam logic [EW-1:0] E_MAX = EW'(STAGES);

    logic [EW-1:0]     s_exp_clamped;
    logic [STAGES-1:0] stage_v;
    logic              skid_full;

    logic              main_v_reg, skid_v_reg;
    logic [OW-1:0]     main_d_reg, skid_d_reg;
    logic              main_o_reg, skid_o_reg;

    // Out-of-range exponents saturate at the pipeline depth rather than wrapping.
    assign s_exp_clamped = (s_exp > E_MAX) ? E_MAX : s_exp;
    assign skid_full     = main_v_reg && skid_v_reg;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            localparam logic [EW-1:0] K = EW'(gi);

            logic            v_in, o_in, sq, rdy, rdy_next;
            logic [OW-1:0]   d_in;
            logic [EW-1:0]   e_in;
            logic [2*OW-1:0] prod;
            logic            v_reg, o_reg;
            logic [OW-1:0]   d_reg;

            if (gi == 0) begin : g_src
                assign v_in = s_valid;
                assign d_in = OW'(s_data);
                assign e_in = s_exp_clamped;
                assign o_in = 1'b0;
            end else begin : g_src
                assign v_in = g_stage[gi-1].v_reg;
                assign d_in = g_stage[gi-1].d_reg;
                assign e_in = g_stage[gi-1].g_exp.e_reg;
                assign o_in = g_stage[gi-1].o_reg;
            end

            if (gi == STAGES - 1) begin : g_rdy
                assign rdy_next = !skid_full;
            end else begin : g_rdy
                assign rdy_next = g_stage[gi+1].rdy;
            end

            // The last stage has no downstream consumer of the exponent.
            if (gi < STAGES - 1) begin : g_exp
                logic [EW-1:0] e_reg;
                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) begin
                        e_reg <= '0;
                    end else if (rdy) begin
                        e_reg <= e_in;
                    end
                end
            end

            assign sq          = K < e_in;
            assign prod        = {{OW{1'b0}}, d_in} * {{OW{1'b0}}, d_in};
            assign rdy         = !v_reg || rdy_next;
            assign stage_v[gi] = v_reg;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    v_reg <= 1'b0;
                    d_reg <= '0;
                    o_reg <= 1'b0;
                end else if (rdy) begin
                    v_reg <= v_in;
                    d_reg <= sq ? prod[OW-1:0] : d_in;
                    o_reg <= o_in || (sq && (|prod[2*OW-1:OW]));
                end
            end
        end
    endgenerate

    assign s_ready = g_stage[0].rdy;

    logic          in_v, in_o, in_fire, drain;
    logic [OW-1:0] in_d;

    assign in_v    = g_stage[STAGES-1].v_reg;
    assign in_d    = g_stage[STAGES-1].d_reg;
    assign in_o    = g_stage[STAGES-1].o_reg;
    assign in_fire = in_v && !skid_full;
    assign drain   = main_v_reg && m_ready;

    // Skid: a full buffer only drains this cycle; the pipe sees the freed slot next cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            main_v_reg <= 1'b0;
            main_d_reg <= '0;
            main_o_reg <= 1'b0;
            skid_v_reg <= 1'b0;
            skid_d_reg <= '0;
            skid_o_reg <= 1'b0;
        end else if (drain) begin
            if (skid_v_reg) begin
                main_d_reg <= skid_d_reg;
                main_o_reg <= skid_o_reg;
                skid_v_reg <= 1'b0;
            end else begin
                main_v_reg <= in_fire;
                if (in_fire) begin
                    main_d_reg <= in_d;
                    main_o_reg <= in_o;
                end
            end
        end else if (in_fire) begin
            if (!main_v_reg) begin
                main_v_reg <= 1'b1;
                main_d_reg <= in_d;
                main_o_reg <= in_o;
            end else begin
                skid_v_reg <= 1'b1;
                skid_d_reg <= in_d;
                skid_o_reg <= in_o;
            end
        end
    end

    assign m_valid = main_v_reg;
    assign m_data  = main_d_reg;
    assign m_ovf   = main_o_reg;
    assign busy    = (|stage_v) || main_v_reg || skid_v_reg;

endmodule

// File: tb/tb_pow_pipe_elastic.sv
// Self-checking bench for pow_pipe_elastic: directed cases plus randomized
// handshake traffic against an arithmetic reference model with an in-order queue.
module tb_pow_pipe_elastic;
    localparam int IW = 32, OW = 64, STAGES = 3, EW = 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [IW-1:0] s_data = '0;
    logic [EW-1:0] s_exp = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [OW-1:0] m_data;
    logic          m_ovf;
    logic          busy;

    always #5 clk = ~clk;

    pow_pipe_elastic #(.IW(IW), .OW(OW), .STAGES(STAGES), .EW(EW)) dut (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_exp(s_exp),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_ovf(m_ovf),
        .busy(busy)
    );

    typedef struct packed {
        logic [63:0] d;
        logic        o;
        logic [31:0] t;
    } exp_t;

    int          n_tests = 0, n_fail = 0;
    int          cyc = 0, n_acc = 0, n_out = 0;
    bit          chk_lat = 1'b0, last_acc = 1'b0;
    exp_t        q[$];
    logic        hold_v = 1'b0, hold_o = 1'b0;
    logic [63:0] hold_d = '0, last_d = '0;
    logic        last_o = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Reference: repeated squaring in wide arithmetic, exponent saturated at STAGES.
    function automatic exp_t model(input logic [31:0] x, input logic [1:0] e);
        exp_t         r;
        logic [127:0] p;
        int           n;
        n   = (int'(e) > STAGES) ? STAGES : int'(e);
        r.d = {32'd0, x};
        r.o = 1'b0;
        r.t = '0;
        for (int i = 0; i < n; i++) begin
            p = {64'd0, r.d} * {64'd0, r.d};
            if (p[127:64] != 64'd0) r.o = 1'b1;
            r.d = p[63:0];
        end
        return r;
    endfunction

    // One clock: inputs were set at the preceding negedge; observe, then advance.
    task automatic step();
        exp_t e;
        #1;
        if (hold_v) begin
            check("hold_valid", {63'd0, m_valid}, 64'd1);
            check("hold_data", m_data, hold_d);
            check("hold_ovf", {63'd0, m_ovf}, {63'd0, hold_o});
        end
        last_acc = s_valid && s_ready;
        if (last_acc) begin
            e   = model(s_data, s_exp);
            e.t = cyc;
            q.push_back(e);
            n_acc++;
        end
        if (m_valid && m_ready) begin
            if (q.size() == 0) begin
                check("unexpected_out", {63'd0, m_valid}, 64'd0);
            end else begin
                e = q.pop_front();
                check("out_data", m_data, e.d);
                check("out_ovf", {63'd0, m_ovf}, {63'd0, e.o});
                if (chk_lat) check("latency", 64'(cyc - int'(e.t)), 64'(STAGES + 1));
                last_d = m_data;
                last_o = m_ovf;
                n_out++;
                $display("[TB] out #%0d data=0x%0h ovf=%0b", n_out, m_data, m_ovf);
            end
        end
        hold_v = m_valid && !m_ready;
        hold_d = m_data;
        hold_o = m_ovf;
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input logic [31:0] x, input logic [1:0] e);
        int w = 0;
        s_valid = 1'b1;
        s_data  = x;
        s_exp   = e;
        do begin
            step();
            w++;
        end while (!last_acc && w < 200);
        if (!last_acc) check("accept_timeout", {63'd0, last_acc}, 64'd1);
        s_valid = 1'b0;
    endtask

    task automatic drain_all();
        int w = 0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        while (q.size() > 0 && w < 200) begin
            step();
            w++;
        end
        if (q.size() != 0) check("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, sent, w;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_m_valid", {63'd0, m_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_m_data", m_data, 64'd0);
        check("rst_m_ovf", {63'd0, m_ovf}, 64'd0);
        rstn = 1'b1;
        #1;
        check("rst_s_ready", {63'd0, s_ready}, 64'd1);
        @(negedge clk);

        // Directed values and latency
        chk_lat = 1'b1;
        m_ready = 1'b1;
        send(32'd2, 2'd3); drain_all(); check("x2_e3", last_d, 64'd256);
        check("x2_e3_ovf", {63'd0, last_o}, 64'd0);
        send(32'd3, 2'd2); drain_all(); check("x3_e2", last_d, 64'd81);
        send(32'd7, 2'd0); drain_all(); check("x7_e0", last_d, 64'd7);
        send(32'd5, 2'd3); drain_all(); check("x5_e3", last_d, 64'd390625);

        // Back-to-back
        for (int i = 1; i <= 8; i++) begin
            s_valid = 1'b1;
            s_data  = 32'(i);
            s_exp   = 2'd1;
            #1;
            check("b2b_s_ready", {63'd0, s_ready}, 64'd1);
            #0;
            step();
        end
        drain_all();
        check("b2b_last", last_d, 64'd64);

        // Overflow
        send(32'h200, 2'd3); drain_all();
        check("ovf_data", last_d, 64'd0);
        check("ovf_flag", {63'd0, last_o}, 64'd1);
        send(32'hFFFF_FFFF, 2'd1); drain_all();
        check("max_sq", last_d, 64'hFFFF_FFFE_0000_0001);
        check("max_sq_ovf", {63'd0, last_o}, 64'd0);

        // Backpressure with gapped input
        chk_lat = 1'b0;
        m_ready = 1'b0;
        acc0 = n_acc;
        sent = 1;
        for (int slot = 0; slot < 10; slot++) begin
            s_valid = 1'b0;
            step();
            if (s_ready) begin
                s_valid = 1'b1;
                s_data  = 32'(sent);
                s_exp   = 2'd0;
                step();
                if (last_acc) sent++;
                s_valid = 1'b0;
            end
        end
        check("bp_accepts", 64'(n_acc - acc0), 64'(STAGES + 2));
        #1;
        check("bp_s_ready", {63'd0, s_ready}, 64'd0);
        check("bp_busy", {63'd0, busy}, 64'd1);
        @(negedge clk);
        m_ready = 1'b1;
        while (sent <= 10) begin
            send(32'(sent), 2'd0);
            sent++;
        end
        drain_all();
        check("bp_total_out", last_d, 64'd10);

        // Randomized traffic
        acc0 = n_acc;
        sent = 0;
        w = 0;
        s_valid = 1'b0;
        while ((sent < 1000 || s_valid || q.size() > 0) && w < 20000) begin
            m_ready = 1'($urandom_range(0, 1));
            if (!s_valid || last_acc) begin
                if (sent < 1000 && $urandom_range(0, 1) == 1) begin
                    s_valid = 1'b1;
                    s_data  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
                    s_exp   = 2'($urandom_range(0, 3));
                    sent++;
                end else begin
                    s_valid = 1'b0;
                end
            end
            step();
            w++;
        end
        check("rand_accepts", 64'(n_acc - acc0), 64'd1000);
        check("rand_queue_empty", 64'(q.size()), 64'd0);
        s_valid = 1'b0;
        drain_all();

        // Reset with items in flight
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(32'(i + 3), 2'd2);
        rstn = 1'b0;
        #1;
        check("midrst_m_valid", {63'd0, m_valid}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        q.delete();
        hold_v = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("no_stale_out", {63'd0, m_valid}, 64'd0);
            @(negedge clk);
        end
        send(32'd2, 2'd1); drain_all();
        check("post_rst_x2_e1", last_d, 64'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
